// File: rtl/softmax_pkg.sv
// Shared types and default latency/width constants for the softmax host controller.
// Imported by the interface, the read-return FIFO and the controller top.
package softmax_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, DRAIN} state_t;

    localparam int EXPONENT_LATENCY     = 23;
    localparam int ACC_LATENCY          = 11;
    localparam int RECIPROCAL_LATENCY   = 15;
    localparam int MULTIPLIER_LATENCY   = 7;
    localparam int LATENCY_MARGIN       = 4;
    localparam int CORE_LATENCY         = EXPONENT_LATENCY + ACC_LATENCY +
                                          RECIPROCAL_LATENCY + MULTIPLIER_LATENCY;
    localparam int DEFAULT_PIPE_LATENCY = CORE_LATENCY + LATENCY_MARGIN;

    localparam int DEFAULT_TOTAL_WORDS  = 1024;
    localparam int DEFAULT_DATA_WIDTH   = 32;
    localparam int DEFAULT_ADDR_WIDTH   = $clog2(DEFAULT_TOTAL_WORDS);
    localparam int DEFAULT_READ_LATENCY = 1;

    // Bits needed to hold 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/softmax_host_ctrl_if.sv
// Host-facing streams of the softmax host controller: input words in, result words out.
// Valid/ready: a word moves on a rising edge where valid && ready are both high; a source
// holds valid and its data stable until that edge, and valid never waits on ready.
interface softmax_host_ctrl_if
    import softmax_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/softmax_skid_fifo.sv
// Small circular FIFO that absorbs read data returning from the softmax output buffer.
// The caller guarantees no push when full and no pop when empty (credit based).
module softmax_skid_fifo
    import softmax_pkg::*;
#(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 33,
    localparam int PTR_W = cnt_width(DEPTH),
    localparam int OCC_W = cnt_width(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [OCC_W-1:0] occupancy
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            occupancy <= occupancy + OCC_W'(push) - OCC_W'(pop);
        end
    end

    assign empty = (occupancy == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/softmax_host_ctrl.sv
// Host-side initiator for the softmax core: streams a vector into the input buffer,
// waits the fixed core latency, then reads results back out as a stream with a last flag.
module softmax_host_ctrl
    import softmax_pkg::*;
#(
    parameter int TOTAL_WORDS  = DEFAULT_TOTAL_WORDS,
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH   = $clog2(TOTAL_WORDS),
    parameter int PIPE_LATENCY = DEFAULT_PIPE_LATENCY,
    parameter int READ_LATENCY = DEFAULT_READ_LATENCY,
    parameter int SKID_DEPTH   = READ_LATENCY + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    softmax_host_ctrl_if.slave    host,
    output logic                  data_in_enable,
    output logic                  data_in_wr_enable,
    output logic [ADDR_WIDTH-1:0] data_in_address,
    output logic [DATA_WIDTH-1:0] data_in,
    output logic                  data_out_enable,
    output logic [ADDR_WIDTH-1:0] data_out_address,
    input  logic [DATA_WIDTH-1:0] data_out,
    output state_t                state_dbg
);
    localparam int CNT_W  = ADDR_WIDTH + 1;
    localparam int WAIT_W = cnt_width(PIPE_LATENCY);
    localparam int OCC_W  = cnt_width(SKID_DEPTH + 1);
    localparam int CRED_W = OCC_W + 1;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    len_q, wr_cnt, rd_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [OCC_W-1:0]    inflight, occupancy;
    logic [CRED_W-1:0]   credits;
    logic [READ_LATENCY-1:0] vld_sr, last_sr;
    logic                len_ok, wr_fire, rd_fire, pop, ret_valid, fifo_empty;
    logic [DATA_WIDTH:0] fifo_head;

    assign len_ok    = (len != '0) && (len <= CNT_W'(TOTAL_WORDS));
    assign wr_fire   = (state == LOAD) && host.s_valid;
    assign pop       = host.m_valid && host.m_ready;
    assign ret_valid = vld_sr[READ_LATENCY-1];
    assign credits   = CRED_W'(inflight) + CRED_W'(occupancy);
    // A pop in the same cycle frees a slot, which keeps the stream at one word per cycle.
    assign rd_fire   = (state == DRAIN) && (rd_cnt < len_q) &&
                       (credits < CRED_W'(SKID_DEPTH) + CRED_W'(pop));

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start && len_ok) state_nxt = LOAD;
            LOAD:    if (wr_fire && (wr_cnt == len_q - CNT_W'(1))) state_nxt = WAIT;
            // Leaving on the count of 1 puts the first read exactly PIPE_LATENCY after the last write.
            WAIT:    if (wait_cnt <= WAIT_W'(1)) state_nxt = DRAIN;
            DRAIN:   if (pop && host.m_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            len_q    <= '0;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            wait_cnt <= '0;
            inflight <= '0;
            vld_sr   <= '0;
            last_sr  <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == DRAIN) && pop && host.m_last;
            err   <= (state == IDLE) && start && !len_ok;
            if ((state == IDLE) && start && len_ok) begin
                len_q  <= len;
                wr_cnt <= '0;
                rd_cnt <= '0;
            end
            if (wr_fire) wr_cnt <= wr_cnt + CNT_W'(1);
            if (rd_fire) rd_cnt <= rd_cnt + CNT_W'(1);
            if ((state == LOAD) && (state_nxt == WAIT))
                wait_cnt <= WAIT_W'(PIPE_LATENCY - 1);
            else if ((state == WAIT) && (wait_cnt != '0))
                wait_cnt <= wait_cnt - WAIT_W'(1);
            vld_sr[0]  <= rd_fire;
            last_sr[0] <= rd_fire && (rd_cnt == len_q - CNT_W'(1));
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_sr[i]  <= vld_sr[i-1];
                last_sr[i] <= last_sr[i-1];
            end
            inflight <= inflight + OCC_W'(rd_fire) - OCC_W'(ret_valid);
        end
    end

    softmax_skid_fifo #(
        .DEPTH (SKID_DEPTH),
        .WIDTH (DATA_WIDTH + 1)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (ret_valid),
        .push_data ({last_sr[READ_LATENCY-1], data_out}),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .occupancy (occupancy)
    );

    assign busy              = (state != IDLE);
    assign state_dbg         = state;
    assign host.s_ready      = (state == LOAD);
    assign host.m_valid      = !fifo_empty;
    assign host.m_data       = fifo_empty ? '0 : fifo_head[DATA_WIDTH-1:0];
    assign host.m_last       = !fifo_empty && fifo_head[DATA_WIDTH];
    assign data_in_enable    = wr_fire;
    assign data_in_wr_enable = wr_fire;
    assign data_in_address   = wr_fire ? wr_cnt[ADDR_WIDTH-1:0] : '0;
    assign data_in           = wr_fire ? host.s_data : '0;
    assign data_out_enable   = rd_fire;
    assign data_out_address  = rd_fire ? rd_cnt[ADDR_WIDTH-1:0] : '0;

endmodule

// File: doc/softmax_host_ctrl.md
Name: softmax_host_ctrl

Overview:
- Host-side initiator for the softmax core's buffer interface. Writes a vector into the core's input buffer and waits a fixed processing time. Then reads the results from the core's output buffer.
- Host side: a start/len command, a valid/ready input stream, and a valid/ready output stream with a last flag.
- Sits between the system DMA/stream fabric and the softmax instance. Replaces the hand-driven address sequencing used in bench stimulus.

Parameters:
- TOTAL_WORDS, 1024, capacity of the softmax buffers in words
- DATA_WIDTH, 32, word width
- ADDR_WIDTH, 10, buffer address width; clog2(TOTAL_WORDS)
- PIPE_LATENCY, 60, fixed cycles after the last write before results are valid: exp 23 + acc 11 + recip 15 + mult 7 + margin 4
- READ_LATENCY, 1, cycles from data_out_enable/address to valid data_out
- SKID_DEPTH, READ_LATENCY+1, output buffer entries (credit limit for outstanding reads)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous active-low reset
- start  in  1  command pulse; sampled in IDLE only
- len  in  ADDR_WIDTH+1  vector length, legal range 1..TOTAL_WORDS
- busy  out  1  high from accepted start until the last output handshake
- done  out  1  one-cycle pulse after the last output handshake
- err  out  1  one-cycle pulse when start is issued with an illegal len
- s_valid  in  1  input word valid
- s_ready  out  1  controller accepts an input word
- s_data  in  DATA_WIDTH  input word
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accepts
- m_data  out  DATA_WIDTH  softmax result word
- m_last  out  1  marks word len-1
- data_in_enable  out  1  to softmax input buffer enable
- data_in_wr_enable  out  1  to softmax input buffer write enable
- data_in_address  out  ADDR_WIDTH  input buffer address
- data_in  out  DATA_WIDTH  input buffer write data
- data_out_enable  out  1  to softmax output buffer read enable
- data_out_address  out  ADDR_WIDTH  output buffer address
- data_out  in  DATA_WIDTH  output buffer read data

Behaviour:
- Reset (rst=0, async): state=IDLE and all counters 0. The skid buffer is emptied. Every output is 0: busy, done, err, s_ready, m_valid, m_last, all enables, all addresses, data_in. A reset mid-transfer aborts the transfer; the result is not retried.
- IDLE:
  - start with 1<=len<=TOTAL_WORDS latches len, sets busy and enters LOAD next cycle.
  - start with len=0 or len>TOTAL_WORDS pulses err for 1 cycle and stays in IDLE.
- LOAD:
  - s_ready=1. Each s_valid&&s_ready writes in the same cycle: data_in_enable=data_in_wr_enable=1, data_in_address=wr_cnt, data_in=s_data. Then wr_cnt increments.
  - Enables are 0 in cycles with no handshake.
  - After the handshake at wr_cnt=len-1: s_ready drops the next cycle and the state goes to WAIT. wait_cnt is loaded with PIPE_LATENCY-1.
- WAIT: wait_cnt decrements each cycle. At 0 the state goes to DRAIN. s_ready=0 and all buffer enables are 0.
- DRAIN:
  - Issue a read (data_out_enable=1, data_out_address=rd_cnt) when credits < SKID_DEPTH. Credits = reads in flight + skid entries occupied.
  - Data returns READ_LATENCY cycles later, tracked by a valid shift register, and is pushed into the skid FIFO.
  - m_valid = skid not empty. m_data/m_last come from the FIFO head; m_last is set on the word from address len-1.
  - A simultaneous push and pop holds occupancy constant.
  - With m_ready held high, throughput is 1 word/cycle after the initial READ_LATENCY.
  - Never more than len reads are issued.
  - After the handshake on the m_last word: done pulses, busy drops, state goes to IDLE.
- start while busy is ignored; it produces no err.
- Address counters never wrap, since len<=TOTAL_WORDS. Address TOTAL_WORDS-1 is legal for len=TOTAL_WORDS.
- Latency from start to first m_valid with no stalls is 1 + len + PIPE_LATENCY + READ_LATENCY cycles.

Decomposition:
- Package softmax_pkg holds:
  - state enum {IDLE, LOAD, WAIT, DRAIN}
  - default latency constants: EXPONENT/ACC/RECIPROCAL/MULTIPLIER latencies and their sum
  - derived width constants
- One sub-module, softmax_skid_fifo: parameterised DEPTH/WIDTH, occupancy output, same clk/rst. It holds the read-return buffering.

Test Plan:
- Reset: assert rst=0 mid-LOAD with len=10 -> every output is 0 immediately. After rst=1, state is IDLE; a new start with len=4 completes normally.
- Basic: len=10, s_data=i*32'h00010000 with s_valid held high -> exactly 10 writes at addresses 0..9 on consecutive cycles. Reads start exactly PIPE_LATENCY cycles after the last write. 10 outputs appear in address order, m_last on the 10th, then done pulses once.
- Backpressure: len=8, m_ready toggles 1,0,0,1 -> no word is lost or duplicated. Reads in flight + buffered never exceed SKID_DEPTH. data_out_address never skips.
- Input gaps: len=5 with s_valid low on alternate cycles -> data_in_enable is high only on handshake cycles; addresses are 0..4.
- Bounds: len=0 and len=1025 -> err pulses, busy stays 0, no buffer enable fires. len=1024 -> final write and read use address 1023.
- Ignored start: start pulse during WAIT -> no effect on len, counters or err.
